vga_pattern_gen: RTL
====================

# vga_pattern_gen

Parametrised VGA timing and test-pattern generator for the Arduino-VGA tile. It is the successor to the fixed 640x480 timing generator plus constant-colour output stage. Timing is set by parameters, colour depth is generic, and four selectable pattern modes switch only at frame boundaries. All outputs are registered and mutually aligned, and the block drives the tile's sync and colour pins directly.

## Interface
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HS_POL / VS_POL, 0 / 0, sync assert level (0 = active-low)
- COLOR_BITS, 2, bits per colour channel
- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient
- solid_rgb  in  3*COLOR_BITS  colour used in mode 0, packed {r,g,b}
- hs, vs  out  1  sync outputs at the configured polarity
- rgb  out  3*COLOR_BITS  pixel colour, packed {r,g,b}; 0 when blanked
- active  out  1  high in the visible region
- x  out  clog2(H_TOTAL)  current column (10 bits at default)
- y  out  clog2(V_TOTAL)  current row (10 bits at default)
- frame_start  out  1  one-clock pulse on the first pixel of each frame
- frame_count  out  8  frame counter, wraps 255 to 0

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Horizontal counter h_cnt runs 0..H_TOTAL-1 and then wraps to 0.
- Vertical counter v_cnt increments on each h_cnt wrap and wraps to 0 after V_TOTAL-1.
- hs is asserted while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vs is asserted while v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- x and y equal h_cnt and v_cnt, including during blanking.
- Frame boundary is h_cnt=0 and v_cnt=0. On that cycle:
  - mode and solid_rgb are latched into shadow registers;
  - frame_count increments (it holds 0 in the first frame after reset);
  - frame_start is generated.
- mode or solid_rgb changes mid-frame do not affect the frame in progress.
- Patterns, computed from the latched mode:
  - Mode 0: rgb = latched solid_rgb.
  - Mode 1: 8 vertical bars, each H_ACTIVE/8 wide, with bar index b = 0..7. Each channel is replicated across COLOR_BITS: r = b[2], g = b[1], b_ch = b[0]. The bar index comes from comparator thresholds, not a divider.
  - Mode 2: 32x32 checkerboard. All channels are all-ones when x[5]^y[5], otherwise 0.
  - Mode 3: r = x[COLOR_BITS+4:5], g = y[COLOR_BITS+4:5], b_ch = frame_count[COLOR_BITS-1:0].
- rgb is forced to 0 whenever active is 0.

## Timing
- A single pipeline stage: every output is registered from the counter state of the previous cycle, so hs, vs, active, x, y, rgb and frame_start are cycle-aligned.
- Reset (rst_n low at a clk edge) sets:
  - h_cnt = 0 and v_cnt = 0;
  - hs = ~HS_POL and vs = ~VS_POL (deasserted);
  - active = 0, rgb = 0, x = 0, y = 0, frame_start = 0, frame_count = 0;
  - shadow mode = 0, shadow solid_rgb = 0.
- First cycle after reset release: the counters sit at (0,0) and present as a frame boundary. The outputs for that state appear one clock later, with frame_start = 1. frame_count increments only on subsequent wraps.
- Reset asserted mid-line or mid-frame takes effect at the next edge and restarts from (0,0). No partial sync pulse is extended.
- frame_count increments at each frame boundary after the first; 255 wraps to 0 with no flag.
- Simultaneous h wrap and v wrap is exactly the frame boundary; the v counter never reaches V_TOTAL.

## Configuration
- VGA_PATTERN_SCROLL_EN defined:
  - modes 1 and 2 use an effective column xs = (x + frame_count) mod H_ACTIVE for pattern lookup;
  - bars and checkerboard scroll left one pixel per frame;
  - the x output itself is unaffected.
- VGA_PATTERN_SCROLL_EN undefined: patterns are static (xs = x), and the offset adder and modulo logic are not synthesised.

## Test plan
- Reset: hold rst_n low 3 clocks -> hs=1, vs=1, rgb=0, active=0, frame_count=0; one clock after release, frame_start=1, x=0, y=0.
- Default parameters, run 2 frames -> hs low for 96 clocks starting at x=656 with an 800-clock period; vs low for 2 lines starting at y=490; frame_start every 420000 clocks.
- Mode 1, COLOR_BITS=2 -> rgb=6'b000000 at x=0, 6'b000011 at x=80, 6'b111111 at x=560; rgb=0 at x=640 and at y=480.
- Mode 0 with solid_rgb=6'b110000 -> switch to mode 2 at y=100; the current frame stays 6'b110000; the next frame shows 6'b111111 at (32,0) and 0 at (32,32).
- Run 256 frames -> frame_count goes 254, 255, 0; in mode 3 the blue channel follows frame_count[1:0].
- Pulse rst_n low at (x=300, y=200) -> the next output cycle shows reset values, and counting resumes from (0,0) with frame_start.

Source files
------------

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pattern control inputs and registered video outputs of vga_pattern_gen
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 2,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 10
);
    logic [1:0]              mode;
    logic [3*COLOR_BITS-1:0] solid_rgb;
    logic                    hs;
    logic                    vs;
    logic [3*COLOR_BITS-1:0] rgb;
    logic                    active;
    logic [X_BITS-1:0]       x;
    logic [Y_BITS-1:0]       y;
    logic                    frame_start;
    logic [7:0]              frame_count;

    modport master (
        input  mode, solid_rgb,
        output hs, vs, rgb, active, x, y, frame_start, frame_count
    );

    modport slave (
        output mode, solid_rgb,
        input  hs, vs, rgb, active, x, y, frame_start, frame_count
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised VGA timing and test-pattern generator (optional VGA_PATTERN_SCROLL_EN)
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_BITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_pattern_gen_if.master  vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_BITS  = $clog2(H_TOTAL);
    localparam int Y_BITS  = $clog2(V_TOTAL);
    localparam int RGB_W   = 3 * COLOR_BITS;

    logic [X_BITS-1:0] h_cnt;
    logic [Y_BITS-1:0] v_cnt;
    logic              first_frame;
    logic [1:0]        mode_q;
    logic [RGB_W-1:0]  solid_q;

    logic              hs_q, vs_q, active_q, fs_q;
    logic [RGB_W-1:0]  rgb_q;
    logic [X_BITS-1:0] x_q;
    logic [Y_BITS-1:0] y_q;
    logic [7:0]        fc_q;

    logic              h_last, v_last, boundary;
    logic [15:0]       hx, vy, xs;
    logic [1:0]        mode_eff;
    logic [RGB_W-1:0]  solid_eff;
    logic [7:0]        fc_next;
    logic              active_next, hs_on, vs_on;
    logic [2:0]        bar;
    logic [RGB_W-1:0]  pat, rgb_next;

    assign h_last   = (h_cnt == X_BITS'(H_TOTAL - 1));
    assign v_last   = (v_cnt == Y_BITS'(V_TOTAL - 1));
    assign boundary = (h_cnt == '0) && (v_cnt == '0);
    assign hx       = 16'(h_cnt);
    assign vy       = 16'(v_cnt);

    // The boundary pixel itself must already use the freshly latched settings.
    assign mode_eff  = boundary ? vid.mode      : mode_q;
    assign solid_eff = boundary ? vid.solid_rgb : solid_q;
    assign fc_next   = (boundary && !first_frame) ? fc_q + 8'd1 : fc_q;

    assign active_next = (hx < 16'(H_ACTIVE)) && (vy < 16'(V_ACTIVE));
    assign hs_on = (hx >= 16'(H_ACTIVE + H_FP)) && (hx < 16'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on = (vy >= 16'(V_ACTIVE + V_FP)) && (vy < 16'(V_ACTIVE + V_FP + V_SYNC));

`ifdef VGA_PATTERN_SCROLL_EN
    // Offset tracks frame_count mod H_ACTIVE incrementally, so one conditional subtract suffices.
    logic [15:0] off, off_next, xs_sum;
    assign off_next = (boundary && !first_frame)
                      ? ((off == 16'(H_ACTIVE - 1)) ? 16'd0 : off + 16'd1) : off;
    assign xs_sum   = hx + off_next;
    assign xs       = (xs_sum >= 16'(H_ACTIVE)) ? xs_sum - 16'(H_ACTIVE) : xs_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) off <= '0;
        else        off <= off_next;
    end
`else
    assign xs = hx;
`endif

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++)
            if (xs >= 16'(k * (H_ACTIVE / 8))) bar = bar + 3'd1;
    end

    always_comb begin
        pat = '0;
        case (mode_eff)
            2'd0: pat = solid_eff;
            2'd1: pat = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
            2'd2: pat = {RGB_W{xs[5] ^ vy[5]}};
            default: pat = {hx[COLOR_BITS+4:5], vy[COLOR_BITS+4:5], fc_next[COLOR_BITS-1:0]};
        endcase
        rgb_next = active_next ? pat : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            first_frame <= 1'b1;
            mode_q      <= '0;
            solid_q     <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            active_q    <= 1'b0;
            rgb_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fs_q        <= 1'b0;
            fc_q        <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + X_BITS'(1);
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + Y_BITS'(1);
            if (boundary) begin
                mode_q      <= vid.mode;
                solid_q     <= vid.solid_rgb;
                first_frame <= 1'b0;
            end
            hs_q     <= hs_on ? HS_POL : ~HS_POL;
            vs_q     <= vs_on ? VS_POL : ~VS_POL;
            active_q <= active_next;
            rgb_q    <= rgb_next;
            x_q      <= h_cnt;
            y_q      <= v_cnt;
            fs_q     <= boundary;
            fc_q     <= fc_next;
        end
    end

    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.active      = active_q;
    assign vid.rgb         = rgb_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.frame_start = fs_q;
    assign vid.frame_count = fc_q;
endmodule
